sha256_msg_padder: RTL and testbench

//  Upstream stage of the SHA-256 peripheral: takes a raw big-endian message as a 32-bit word stream and

---
 rtl/sha256_msg_padder_pkg.sv | 23 ++
 rtl/sha256_msg_padder_if.sv | 31 +++
 rtl/sha256_pad_merge.sv | 24 ++
 rtl/sha256_msg_padder.sv | 154 +++++++++++++++
 tb/tb_sha256_msg_padder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_msg_padder_pkg.sv
// Shared definitions for the SHA-256 message padder:
// FSM state encoding, padding constants and the last-word byte-count clamp.
package sha256_pkg;

   typedef enum logic [2:0] {
      S_DATA,
      S_PAD80,
      S_ZERO,
      S_LEN_HI,
      S_LEN_LO
   } state_t;

   localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
   localparam int unsigned WORDS_PER_BLOCK = 16;
   localparam int unsigned LEN_HI_IDX      = 14;
   localparam int unsigned LEN_LO_IDX      = 15;

   // A final word never carries more than four bytes; larger counts mean "full word".
   function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
      return (n > 3'd4) ? 3'd4 : n;
   endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream bundle between the message source, the padder and the hash core.
// The master modport is the source/sink side (testbench or neighbouring
// blocks); the slave modport is the padder itself.
interface sha256_msg_padder_if;

   logic [31:0] s_data;
   logic [2:0]  s_last_bytes;
   logic        s_last;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_block_last;
   logic        m_msg_last;
   logic        m_valid;
   logic        m_ready;

   modport master (
      output s_data, s_last_bytes, s_last, s_valid,
      input  s_ready,
      input  m_data, m_block_last, m_msg_last, m_valid,
      output m_ready
   );

   modport slave (
      input  s_data, s_last_bytes, s_last, s_valid,
      output s_ready,
      output m_data, m_block_last, m_msg_last, m_valid,
      input  m_ready
   );

endinterface

// File: rtl/sha256_pad_merge.sv
// Combinational merge of the final message word with the 0x80 marker:
// keeps the first n data bytes, places 0x80 at byte n, zeroes the rest.
// n = 0 yields the bare marker word, n >= 4 passes the data word unchanged.
module sha256_pad_merge
   import sha256_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  n,
   output logic [31:0] word
);

   // Select the merged word by the clamped valid-byte count.
   always_comb begin
      word = PAD_WORD;
      case (clamp_bytes(n))
         3'd0:    word = PAD_WORD;
         3'd1:    word = {data[31:24], 24'h80_0000};
         3'd2:    word = {data[31:16], 16'h8000};
         3'd3:    word = {data[31:8],  8'h80};
         default: word = data;
      endcase
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a big-endian 32-bit message word stream into
// padded 512-bit blocks (marker, zero fill, 64-bit bit length) emitted as
// 16-word groups through a single output register slot.
// Optional feature macro: SHA256_PADDER_BYPASS_EN (adds cfg_bypass pass-through).
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic aclk,
   input  logic areset,
`ifdef SHA256_PADDER_BYPASS_EN
   input  logic cfg_bypass,
`endif
   sha256_msg_padder_if.slave bus
);

   state_t            state, state_nxt;
   logic [3:0]        idx;
   logic [LEN_W-1:0]  byte_cnt, byte_cnt_nxt;
   logic [LEN_W-1:0]  bit_cnt;
   logic [63:0]       bit_len;
   logic [2:0]        last_n;
   logic [31:0]       merged;
   logic [31:0]       data_nxt;
   logic              msg_last_nxt;
   logic              load;
   logic              out_load;
   logic              accept;
   logic              bypass_eff;
   state_t            after_marker;

   sha256_pad_merge u_merge (
      .data (bus.s_data),
      .n    (bus.s_last_bytes),
      .word (merged)
   );

   assign load        = !bus.m_valid | bus.m_ready;
   assign bus.s_ready = !areset & (state == S_DATA) & load;
   assign accept      = bus.s_valid & bus.s_ready;
   assign last_n      = clamp_bytes(bus.s_last_bytes);
   assign bit_cnt     = byte_cnt << 3;
   assign bit_len     = 64'(bit_cnt);
   // The word being loaded sits at idx; the length words must land on 14/15.
   assign after_marker = (idx + 4'd1 == 4'(LEN_HI_IDX)) ? S_LEN_HI : S_ZERO;

`ifdef SHA256_PADDER_BYPASS_EN
   logic bypass_q;
   logic msg_active;
   logic msg_start;

   assign msg_start  = !msg_active & (idx == 4'd0);
   assign bypass_eff = msg_start ? cfg_bypass : bypass_q;

   // Latch the bypass choice on the first accepted word of each message.
   always_ff @(posedge aclk) begin
      if (areset) begin
         bypass_q   <= 1'b0;
         msg_active <= 1'b0;
      end else if (accept) begin
         if (msg_start) bypass_q <= cfg_bypass;
         msg_active <= !bus.s_last;
      end
   end
`else
   assign bypass_eff = 1'b0;
`endif

   // Next state, next output word and byte-count update.
   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      data_nxt     = bus.m_data;
      msg_last_nxt = 1'b0;
      out_load     = 1'b0;
      case (state)
         S_DATA: begin
            if (accept) begin
               out_load = 1'b1;
               if (!bus.s_last) begin
                  data_nxt     = bus.s_data;
                  byte_cnt_nxt = byte_cnt + LEN_W'(4);
               end else if (bypass_eff) begin
                  data_nxt     = bus.s_data;
                  msg_last_nxt = 1'b1;
                  byte_cnt_nxt = '0;
               end else begin
                  data_nxt     = merged;
                  byte_cnt_nxt = byte_cnt + LEN_W'(last_n);
                  state_nxt    = (last_n == 3'd4) ? S_PAD80 : after_marker;
               end
            end
         end
         S_PAD80: begin
            if (load) begin
               out_load  = 1'b1;
               data_nxt  = PAD_WORD;
               state_nxt = after_marker;
            end
         end
         S_ZERO: begin
            if (load) begin
               out_load  = 1'b1;
               data_nxt  = '0;
               state_nxt = after_marker;
            end
         end
         S_LEN_HI: begin
            if (load) begin
               out_load  = 1'b1;
               data_nxt  = bit_len[63:32];
               state_nxt = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (load) begin
               out_load     = 1'b1;
               data_nxt     = bit_len[31:0];
               msg_last_nxt = 1'b1;
               byte_cnt_nxt = '0;
               state_nxt    = S_DATA;
            end
         end
         default: state_nxt = S_DATA;
      endcase
   end

   // State, counters and the output register slot.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state            <= S_DATA;
         idx              <= '0;
         byte_cnt         <= '0;
         bus.m_valid      <= 1'b0;
         bus.m_data       <= '0;
         bus.m_block_last <= 1'b0;
         bus.m_msg_last   <= 1'b0;
      end else begin
         state    <= state_nxt;
         byte_cnt <= byte_cnt_nxt;
         if (out_load) begin
            bus.m_valid      <= 1'b1;
            bus.m_data       <= data_nxt;
            bus.m_block_last <= (idx == 4'(LEN_LO_IDX));
            bus.m_msg_last   <= msg_last_nxt;
            idx              <= idx + 4'd1;
         end else if (load) begin
            bus.m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder: known messages with hand-computed
// padded word sequences, stalls on both sides, and reset mid-message.
module tb_sha256_msg_padder;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   logic stall_en = 1'b0;
`ifdef SHA256_PADDER_BYPASS_EN
   logic cfg_bypass = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] q_data[$];
   logic        q_blk[$];
   logic        q_msg[$];

   logic        held_v = 1'b0;
   logic [31:0] held_d = '0;

   sha256_msg_padder_if bus();

   sha256_msg_padder #(.LEN_W(64)) dut (
      .aclk       (aclk),
      .areset     (areset),
`ifdef SHA256_PADDER_BYPASS_EN
      .cfg_bypass (cfg_bypass),
`endif
      .bus        (bus)
   );

   always #5 aclk = ~aclk;

   // Downstream ready: held high, or random when stalls are enabled.
   always @(negedge aclk) begin
      bus.m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Capture every accepted output word and check hold stability under stall.
   always @(posedge aclk) begin
      if (areset) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            total++;
            assert (bus.m_data === held_d)
            else begin
               bad++;
               $error("FAIL stall_hold obs=%h exp=%h", bus.m_data, held_d);
            end
         end
         if (bus.m_valid && bus.m_ready) begin
            q_data.push_back(bus.m_data);
            q_blk.push_back(bus.m_block_last);
            q_msg.push_back(bus.m_msg_last);
         end
         held_v = bus.m_valid && !bus.m_ready;
         held_d = bus.m_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] lb,
                            input int unsigned gap);
      int unsigned g;
      repeat (gap) @(negedge aclk);
      @(negedge aclk);
      bus.s_data       = d;
      bus.s_last       = last;
      bus.s_last_bytes = lb;
      bus.s_valid      = 1'b1;
      #1;
      g = 0;
      while (!bus.s_ready && g < 500) begin
         @(negedge aclk);
         #1;
         g++;
      end
      if (g >= 500) begin
         total++;
         bad++;
         $error("FAIL s_ready_timeout obs=0 exp=1");
      end
      @(posedge aclk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int n);
      int unsigned g;
      g = 0;
      while (q_data.size() < n && g < 2000) begin
         @(posedge aclk);
         g++;
      end
      repeat (4) @(negedge aclk);
      chk({tag, "_count"}, 32'(q_data.size()), 32'(n));
   endtask

   task automatic check_word(input string tag, input int i, input logic [31:0] d,
                             input logic blk, input logic msg);
      logic [31:0] od;
      logic        ob;
      logic        om;
      od = 'x;
      ob = 1'bx;
      om = 1'bx;
      if (i < q_data.size()) begin
         od = q_data[i];
         ob = q_blk[i];
         om = q_msg[i];
      end
      chk($sformatf("%s_data[%0d]", tag, i), od, d);
      chk($sformatf("%s_blk[%0d]", tag, i), 32'(ob), 32'(blk));
      chk($sformatf("%s_msg[%0d]", tag, i), 32'(om), 32'(msg));
   endtask

   task automatic clear_q();
      q_data.delete();
      q_blk.delete();
      q_msg.delete();
   endtask

   initial begin
      bus.s_data       = '0;
      bus.s_last       = 1'b0;
      bus.s_last_bytes = '0;
      bus.s_valid      = 1'b0;

      // Reset state
      repeat (3) @(negedge aclk);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data", bus.m_data, 32'h0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_blk", 32'(bus.m_block_last), 32'd0);
      chk("rst_msg", 32'(bus.m_msg_last), 32'd0);
      areset = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

      // "abc"
      send_word(32'h6162_6300, 1'b1, 3'd3, 0);
      wait_out("abc", 16);
      for (int i = 0; i < 16; i++)
         check_word("abc", i, (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h18 : 32'h0,
                    i == 15, i == 15);
      clear_q();

      // Empty message
      send_word(32'h0, 1'b1, 3'd0, 0);
      wait_out("empty", 16);
      for (int i = 0; i < 16; i++)
         check_word("empty", i, (i == 0) ? 32'h8000_0000 : 32'h0, i == 15, i == 15);
      clear_q();

      // 14 full words: marker lands at index 14, extra block
      for (int i = 0; i < 14; i++)
         send_word(32'h1111_0000 + 32'(i), i == 13, 3'd4, 0);
      wait_out("w14", 32);
      for (int i = 0; i < 32; i++)
         check_word("w14", i,
                    (i < 14) ? 32'h1111_0000 + 32'(i) :
                    (i == 14) ? 32'h8000_0000 :
                    (i == 31) ? 32'h0000_01C0 : 32'h0,
                    (i == 15) || (i == 31), i == 31);
      clear_q();

      // Two valid bytes
      send_word(32'hDEAD_BEEF, 1'b1, 3'd2, 0);
      wait_out("n2", 16);
      for (int i = 0; i < 16; i++)
         check_word("n2", i, (i == 0) ? 32'hDEAD_8000 : (i == 15) ? 32'h10 : 32'h0,
                    i == 15, i == 15);
      clear_q();

      // Out-of-range byte count behaves as a full word
      send_word(32'hDEAD_BEEF, 1'b1, 3'd7, 0);
      wait_out("n7", 16);
      for (int i = 0; i < 16; i++)
         check_word("n7", i,
                    (i == 0) ? 32'hDEAD_BEEF : (i == 1) ? 32'h8000_0000 :
                    (i == 15) ? 32'h20 : 32'h0,
                    i == 15, i == 15);
      clear_q();

      // 16 full words with random downstream stalls and upstream gaps
      stall_en = 1'b1;
      for (int i = 0; i < 16; i++)
         send_word(32'hADAD_ADAD, i == 15, 3'd4, $urandom_range(0, 2));
      wait_out("w16", 32);
      stall_en = 1'b0;
      for (int i = 0; i < 32; i++)
         check_word("w16", i,
                    (i < 16) ? 32'hADAD_ADAD :
                    (i == 16) ? 32'h8000_0000 :
                    (i == 31) ? 32'h0000_0200 : 32'h0,
                    (i == 15) || (i == 31), i == 31);
      clear_q();

      // Reset mid-message, then a fresh message starts at index 0
      for (int i = 0; i < 5; i++)
         send_word(32'h5555_0000 + 32'(i), 1'b0, 3'd0, 0);
      @(negedge aclk);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      clear_q();
      repeat (3) @(negedge aclk);
      chk("midrst_no_output", 32'(q_data.size()), 32'd0);
      send_word(32'h6162_6300, 1'b1, 3'd3, 0);
      wait_out("abc2", 16);
      for (int i = 0; i < 16; i++)
         check_word("abc2", i, (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h18 : 32'h0,
                    i == 15, i == 15);
      clear_q();

`ifdef SHA256_PADDER_BYPASS_EN
      // Bypass: words pass through unchanged, no padding
      cfg_bypass = 1'b1;
      for (int i = 0; i < 16; i++)
         send_word(32'h5A00_0000 + 32'(i), i == 15, 3'd4, 0);
      wait_out("byp", 16);
      for (int i = 0; i < 16; i++)
         check_word("byp", i, 32'h5A00_0000 + 32'(i), i == 15, i == 15);
      cfg_bypass = 1'b0;
      clear_q();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
